display_drop_driver: RTL and testbench
======================================

# display_drop_driver

Sequential back end for the baggage-drop status path. It consumes the four 7-segment status words and the `drop_activated` flag from the baggage-drop decision logic. It time-multiplexes the four words onto one shared segment bus of a 4-digit display, and converts each new drop decision into a request/acknowledge handshake with the hatch actuator, including timeout fault detection.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per digit slot. Must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 16: blanking cycles at the start of each slot, for anti-ghosting. Must be ≥ 1.
- `ACK_TIMEOUT`, default 50000: cycles allowed in each handshake phase before a fault is raised.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `seg_in1`..`seg_in4`  in  7 each  status words from the decision logic. `seg_in1` is the leftmost digit. Bit 0 = segment a … bit 6 = segment g, active-high.
- `drop_activated`  in  1  drop decision, same clock domain.
- `hatch_ack`  in  1  actuator acknowledge.
- `seg_out`  out  7  shared segment bus, same bit order.
- `dig_sel`  out  4  one-hot digit enable, active-high. Bit 0 = digit 1.
- `hatch_req`  out  1  drop request to actuator.
- `drop_done`  out  1  one-cycle pulse when a handshake completes.
- `hatch_fault`  out  1  sticky fault flag.

## Operation
- **Scanner**
  - Prescaler `cnt` counts 0..`SCAN_DIV`-1 and wraps.
  - Digit index `idx` increments on each `cnt` wrap. It wraps 3→0.
- **Frame snapshot**
  - The shadow registers sh[0..3] load `seg_in1`..`seg_in4` on the edge where `idx` wraps 3→0.
  - They also load on the first edge after reset release.
  - A frame is therefore always coherent. Input changes mid-frame appear only in the next frame.
  - While `hatch_fault`=1, the snapshot loads the constant pattern FAIL instead: 1110001, 1110111, 0000110, 0111000.
- **Slot output**
  - For `cnt` < `BLANK_CYC`: `dig_sel`=0000 and `seg_out`=0.
  - Otherwise: `dig_sel`=one-hot(`idx`) and `seg_out`=sh[`idx`].
- **Drop FSM**
  - States: IDLE, REQ, RELEASE, DONE, FAULT.
  - `drop_prev` registers `drop_activated`. A rise is `drop_activated` & !`drop_prev`.
  - IDLE: a rise moves to REQ and clears the timer.
  - REQ: `hatch_req`=1.
    - `hatch_ack`=1 moves to RELEASE and clears the timer.
    - Timer reaching `ACK_TIMEOUT` moves to FAULT.
  - RELEASE: `hatch_req`=0.
    - `hatch_ack`=0 moves to DONE.
    - Timer reaching `ACK_TIMEOUT` moves to FAULT.
  - DONE: `drop_done`=1 for exactly one cycle, then IDLE.
  - FAULT: `hatch_req`=0 and `hatch_fault`=1. Terminal until reset. All drop rises are ignored.
- **Boundaries**
  - `drop_activated` falling during REQ or RELEASE: the handshake continues, because the command is committed.
  - A new rise in any state other than IDLE is ignored. There is no queuing.
  - Ack and timeout on the same edge: ack wins, with no fault.
  - `drop_prev` resets to 1. A level held high through reset does not trigger a drop.
  - Timer and counter widths are $clog2 of their parameter. No counter ever overflows.

## Timing
- **Reset values:**
  - Outputs: `seg_out`=0, `dig_sel`=0, `hatch_req`=0, `drop_done`=0, `hatch_fault`=0.
  - Internal state: `cnt`=0, `idx`=0, shadows=0, FSM=IDLE, `drop_prev`=1.
- All outputs are registered and glitch-free.
- Assertion of `rst_n` clears every output immediately, including mid-handshake.
- **Display timing:**
  - Each digit is active for `SCAN_DIV`-`BLANK_CYC` consecutive cycles.
  - Consecutive active windows are separated by `BLANK_CYC` dark cycles.
  - Frame period is 4·`SCAN_DIV`.
- **Drop latency:**
  - Rise sampled at edge k: `hatch_req` is high after edge k.
  - Ack sampled high at edge m: `hatch_req` is low after edge m.
  - Ack sampled low at edge n: `drop_done` is high for the cycle after edge n.
- **Timeout:** `hatch_req` stays high for at most `ACK_TIMEOUT` cycles. `hatch_fault` rises on the following edge.

## Structure
- **Package `display_drop_pkg`:**
  - Drop FSM state enum.
  - `NUM_DIGITS`=4.
  - `SEG_F`, `SEG_A`, `SEG_I`, `SEG_L` constants.
- **Sub-module `seg_scanner`:**
  - Contents: prescaler, `idx`, shadow registers, blanking, output registers.
  - Inputs: the four words plus a fault-override select.
- **Top:** instantiates `seg_scanner` and holds the drop FSM, timer and edge detector.

## Test plan
Common settings: `SCAN_DIV`=8, `BLANK_CYC`=2, `ACK_TIMEOUT`=20.
- **Cold display.** Reset, then drive cold (0111001, 1011100, 0111000, 1011110).
  - Required: 2 dark cycles, then `dig_sel`=0001 with `seg_out`=0111001 for 6 cycles, then 2 dark cycles, then 0010 with 1011100, and so on.
  - Frame repeats every 32 cycles.
- **Mid-frame change.** Switch inputs to drop (1011110, 1010000, 1011100, 1110011) during slot 2.
  - Required: slots 2–3 still show cold; the next frame shows drop.
- **Normal handshake.** Raise `drop_activated`, give ack 5 cycles after `hatch_req`, drop ack 3 cycles later.
  - Required: `hatch_req` high for 5 cycles, a single `drop_done` pulse, and no second request while `drop_activated` stays high.
- **Timeout.** Raise `drop_activated` and never ack.
  - Required: `hatch_req` high for 20 cycles, then `hatch_fault`=1.
  - The next frame shows FAIL.
  - A later falling and rising edge on `drop_activated` produces no request.
- **Ack/timeout race.** Assert ack on exactly the 20th REQ cycle.
  - Required: RELEASE and then DONE, with `hatch_fault` staying 0.
- **Reset mid-request.** Assert `rst_n`=0 mid-REQ with `drop_activated` held high.
  - Required: `hatch_req` and `dig_sel` go to 0 immediately.
  - After release, no request is issued until `drop_activated` falls and rises again.

Source files
------------

// File: rtl/display_drop_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : display_drop_pkg                                           |
// | Description : Shared types and constants for the baggage-drop display    |
// |               and hatch handshake back end.                              |
// |               - drop_state_t : hatch handshake FSM states                |
// |               - NUM_DIGITS   : digits on the multiplexed display         |
// |               - SEG_F/A/I/L  : fault banner glyphs, bit 0 = segment a    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package display_drop_pkg;

   localparam int NUM_DIGITS = 4;

   // Glyphs written MSB (segment g) first, active-high.
   localparam logic [6:0] SEG_F = 7'b1110001;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_I = 7'b0000110;
   localparam logic [6:0] SEG_L = 7'b0111000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_RELEASE = 3'd2,
      ST_DONE    = 3'd3,
      ST_FAULT   = 3'd4
   } drop_state_t;

endpackage
`default_nettype wire

// File: rtl/display_drop_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : display_drop_driver_if                                     |
// | Description : Status words and drop decision in, multiplexed display bus |
// |               and hatch handshake out.                                   |
// |               master : the driver (consumes words/flag/ack, drives bus)  |
// |               slave  : the environment (decision logic, display, hatch)  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface display_drop_driver_if;
   import display_drop_pkg::*;

   logic [6:0]            seg_in1;
   logic [6:0]            seg_in2;
   logic [6:0]            seg_in3;
   logic [6:0]            seg_in4;
   logic                  drop_activated;
   logic                  hatch_ack;
   logic [6:0]            seg_out;
   logic [NUM_DIGITS-1:0] dig_sel;
   logic                  hatch_req;
   logic                  drop_done;
   logic                  hatch_fault;

   modport master (
      input  seg_in1, seg_in2, seg_in3, seg_in4, drop_activated, hatch_ack,
      output seg_out, dig_sel, hatch_req, drop_done, hatch_fault
   );

   modport slave (
      output seg_in1, seg_in2, seg_in3, seg_in4, drop_activated, hatch_ack,
      input  seg_out, dig_sel, hatch_req, drop_done, hatch_fault
   );

endinterface
`default_nettype wire

// File: rtl/display_drop_driver_seg_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg_scanner                                                |
// | Description : Time-multiplexes four 7-segment words onto one shared bus. |
// |               A frame is snapshotted at its start so it is always        |
// |               coherent; each slot begins with a blanking interval.       |
// | Ports       : clk, rst_n           clock, async active-low reset         |
// |               seg_in1..seg_in4     words, seg_in1 = leftmost digit       |
// |               fault_sel            snapshot the FAIL banner instead      |
// |               seg_out              registered shared segment bus         |
// |               dig_sel              registered one-hot digit enable       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module seg_scanner
   import display_drop_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic [6:0]            seg_in1,
   input  wire logic [6:0]            seg_in2,
   input  wire logic [6:0]            seg_in3,
   input  wire logic [6:0]            seg_in4,
   input  wire logic                  fault_sel,
   output logic      [6:0]            seg_out,
   output logic      [NUM_DIGITS-1:0] dig_sel
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] c_blank    = CW'(BLANK_CYC);
   localparam logic [IW-1:0] c_idx_last = IW'(NUM_DIGITS - 1);

   logic [CW-1:0] r_cnt;
   logic [IW-1:0] r_idx;
   logic          r_primed;
   logic [6:0]    r_sh [NUM_DIGITS];

   logic          w_wrap;
   logic          w_load;
   logic [CW-1:0] w_cnt_next;
   logic [IW-1:0] w_idx_next;
   logic [6:0]    w_frame   [NUM_DIGITS];
   logic [6:0]    w_sh_next [NUM_DIGITS];

   always_comb begin
      w_wrap     = (r_cnt == c_cnt_last);
      w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
      w_idx_next = w_wrap ? r_idx + 1'b1 : r_idx;
      // Snapshot on the first edge out of reset and at every frame start.
      w_load     = !r_primed || (w_wrap && (r_idx == c_idx_last));
      w_frame[0] = fault_sel ? SEG_F : seg_in1;
      w_frame[1] = fault_sel ? SEG_A : seg_in2;
      w_frame[2] = fault_sel ? SEG_I : seg_in3;
      w_frame[3] = fault_sel ? SEG_L : seg_in4;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_sh_next[i] = w_load ? w_frame[i] : r_sh[i];
      end
   end

   // Outputs are registered from the next-state counters so that the bus
   // lines up with cnt/idx rather than lagging them by a cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_idx    <= '0;
         r_primed <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_sh[i] <= '0;
         end
         seg_out  <= '0;
         dig_sel  <= '0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_idx    <= w_idx_next;
         r_primed <= 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_sh[i] <= w_sh_next[i];
         end
         if (w_cnt_next < c_blank) begin
            seg_out <= '0;
            dig_sel <= '0;
         end else begin
            seg_out <= w_sh_next[w_idx_next];
            dig_sel <= NUM_DIGITS'(1) << w_idx_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/display_drop_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : display_drop_driver                                        |
// | Description : Baggage-drop status back end. Drives the multiplexed       |
// |               4-digit display and turns each new drop decision into a    |
// |               request/acknowledge handshake with the hatch actuator,     |
// |               latching a sticky fault if either phase times out.         |
// | Ports       : clk, rst_n   clock, async active-low reset                 |
// |               bus (master) seg_in1..4, drop_activated, hatch_ack in;     |
// |                            seg_out, dig_sel, hatch_req, drop_done,       |
// |                            hatch_fault out (all registered)              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module display_drop_driver
   import display_drop_pkg::*;
#(
   parameter int SCAN_DIV    = 1000,
   parameter int BLANK_CYC   = 16,
   parameter int ACK_TIMEOUT = 50000
) (
   input wire logic              clk,
   input wire logic              rst_n,
   display_drop_driver_if.master bus
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   // Timer counts 0..ACK_TIMEOUT-1 inside a phase; the last value marks the
   // ACK_TIMEOUT-th cycle, so it never needs to hold ACK_TIMEOUT itself.
   localparam logic [TW-1:0] c_timer_last = TW'(ACK_TIMEOUT - 1);

   drop_state_t   r_state;
   logic [TW-1:0] r_timer;
   logic          r_drop_prev;
   logic          r_req;
   logic          r_done;
   logic          r_fault;
   logic          w_rise;

   assign w_rise = bus.drop_activated & ~r_drop_prev;

   seg_scanner #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_seg_scanner (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_in1   (bus.seg_in1),
      .seg_in2   (bus.seg_in2),
      .seg_in3   (bus.seg_in3),
      .seg_in4   (bus.seg_in4),
      .fault_sel (r_fault),
      .seg_out   (bus.seg_out),
      .dig_sel   (bus.dig_sel)
   );

   // drop_prev resets high so a level held through reset is not a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_drop_prev <= 1'b1;
         r_req       <= 1'b0;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_drop_prev <= bus.drop_activated;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state <= ST_REQ;
                  r_timer <= '0;
                  r_req   <= 1'b1;
               end
            end
            ST_REQ: begin
               // Ack is tested first so it wins a same-edge timeout.
               if (bus.hatch_ack) begin
                  r_state <= ST_RELEASE;
                  r_timer <= '0;
                  r_req   <= 1'b0;
               end else if (r_timer == c_timer_last) begin
                  r_state <= ST_FAULT;
                  r_req   <= 1'b0;
                  r_fault <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!bus.hatch_ack) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else if (r_timer == c_timer_last) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            ST_FAULT: begin
               r_req   <= 1'b0;
               r_fault <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hatch_req   = r_req;
   assign bus.drop_done   = r_done;
   assign bus.hatch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_display_drop_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_display_drop_driver                                     |
// | Description : Self-checking bench for display_drop_driver with           |
// |               SCAN_DIV=8, BLANK_CYC=2, ACK_TIMEOUT=20.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_display_drop_driver;

   localparam logic [6:0] c_cold [4] = '{7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
   localparam logic [6:0] c_drop [4] = '{7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
   localparam logic [6:0] c_fail [4] = '{7'b1110001, 7'b1110111, 7'b0000110, 7'b0111000};

   logic clk = 1'b0;
   logic rst_n;
   logic [6:0] in_w [4];
   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the display: cycle count since reset release and
   // the frame contents the display should currently be showing.
   int         m_t;
   logic [6:0] m_frame [4];
   bit         m_fault;

   display_drop_driver_if bus ();

   assign bus.seg_in1 = in_w[0];
   assign bus.seg_in2 = in_w[1];
   assign bus.seg_in3 = in_w[2];
   assign bus.seg_in4 = in_w[3];

   display_drop_driver #(
      .SCAN_DIV    (8),
      .BLANK_CYC   (2),
      .ACK_TIMEOUT (20)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // A new frame begins every 32 cycles; its words are whatever was on the
   // inputs (or the FAIL banner) on the edge entering it, plus once right
   // after reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= 0;
         for (int i = 0; i < 4; i++) m_frame[i] <= '0;
      end else begin
         if (m_t == 0 || (m_t % 32) == 31) begin
            for (int i = 0; i < 4; i++) m_frame[i] <= m_fault ? c_fail[i] : in_w[i];
         end
         m_t <= m_t + 1;
      end
   end

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_fault = 1'b0;
      for (int i = 0; i < 4; i++) in_w[i] = 7'($urandom);
      repeat (2) @(negedge clk);
      n_checks++; if (bus.seg_out !== 7'd0) $display("FAIL reset_seg_out: got %b expected 0", bus.seg_out); else n_pass++;
      n_checks++; if (bus.dig_sel !== 4'd0) $display("FAIL reset_dig_sel: got %b expected 0", bus.dig_sel); else n_pass++;
      n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL reset_hatch_req: got %b expected 0", bus.hatch_req); else n_pass++;
      n_checks++; if (bus.drop_done !== 1'b0) $display("FAIL reset_drop_done: got %b expected 0", bus.drop_done); else n_pass++;
      n_checks++; if (bus.hatch_fault !== 1'b0) $display("FAIL reset_hatch_fault: got %b expected 0", bus.hatch_fault); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.dig_sel !== 4'd0) $display("FAIL reset_first_dark: got %b expected 0", bus.dig_sel); else n_pass++;
   endtask

   task automatic test_cold_display();
      int pos, slot;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) in_w[i] = c_cold[i];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 64; c++) begin
         pos  = c % 8;
         slot = (c / 8) % 4;
         exp_dig = (pos < 2) ? 4'd0 : 4'b0001 << slot;
         exp_seg = (pos < 2) ? 7'd0 : c_cold[slot];
         n_checks++; if (bus.dig_sel !== exp_dig) $display("FAIL cold_dig_sel t=%0d: got %b expected %b", c, bus.dig_sel, exp_dig); else n_pass++;
         n_checks++; if (bus.seg_out !== exp_seg) $display("FAIL cold_seg_out t=%0d: got %b expected %b", c, bus.seg_out, exp_seg); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_mid_frame();
      int pos, slot, chg_frame;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      for (int i = 0; i < 40 && (m_t % 32) != 11; i++) @(negedge clk);
      // Switch inside the second digit's active window.
      for (int i = 0; i < 4; i++) in_w[i] = c_drop[i];
      chg_frame = m_t / 32;
      for (int c = 0; c < 56; c++) begin
         pos  = m_t % 8;
         slot = (m_t / 8) % 4;
         exp_dig = (pos < 2) ? 4'd0 : 4'b0001 << slot;
         exp_seg = (pos < 2) ? 7'd0 : ((m_t / 32 == chg_frame) ? c_cold[slot] : c_drop[slot]);
         n_checks++; if (bus.dig_sel !== exp_dig) $display("FAIL midframe_dig_sel t=%0d: got %b expected %b", m_t, bus.dig_sel, exp_dig); else n_pass++;
         n_checks++; if (bus.seg_out !== exp_seg) $display("FAIL midframe_seg_out t=%0d: got %b expected %b", m_t, bus.seg_out, exp_seg); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_random_display();
      int pos, slot;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      for (int c = 0; c < 300; c++) begin
         pos  = m_t % 8;
         slot = (m_t / 8) % 4;
         exp_dig = (pos < 2) ? 4'd0 : 4'b0001 << slot;
         exp_seg = (pos < 2) ? 7'd0 : m_frame[slot];
         n_checks++; if (bus.dig_sel !== exp_dig) $display("FAIL rand_dig_sel t=%0d: got %b expected %b", m_t, bus.dig_sel, exp_dig); else n_pass++;
         n_checks++; if (bus.seg_out !== exp_seg) $display("FAIL rand_seg_out t=%0d: got %b expected %b", m_t, bus.seg_out, exp_seg); else n_pass++;
         if ($urandom_range(0, 5) == 0) in_w[$urandom_range(0, 3)] = 7'($urandom);
         @(negedge clk);
      end
   endtask

   // Rise, ack after d request cycles, release ack r cycles later. With
   // bounce, drop_activated falls during REQ and rises again during RELEASE.
   task automatic run_handshake(input int d, input int r, input bit bounce, input string name);
      bus.drop_activated = 1'b0;
      bus.hatch_ack = 1'b0;
      repeat (2) @(negedge clk);
      bus.drop_activated = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= d; i++) begin
         n_checks++; if (bus.hatch_req !== 1'b1) $display("FAIL %s_req_high cyc=%0d: got %b expected 1", name, i, bus.hatch_req); else n_pass++;
         n_checks++; if (bus.hatch_fault !== 1'b0) $display("FAIL %s_no_fault cyc=%0d: got %b expected 0", name, i, bus.hatch_fault); else n_pass++;
         if (i == d) begin
            bus.hatch_ack = 1'b1;
            if (bounce) bus.drop_activated = 1'b0;
         end
         @(negedge clk);
      end
      for (int i = 1; i <= r; i++) begin
         n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL %s_req_released cyc=%0d: got %b expected 0", name, i, bus.hatch_req); else n_pass++;
         n_checks++; if (bus.drop_done !== 1'b0) $display("FAIL %s_done_early cyc=%0d: got %b expected 0", name, i, bus.drop_done); else n_pass++;
         if (i == 1 && bounce) bus.drop_activated = 1'b1;
         if (i == r) bus.hatch_ack = 1'b0;
         @(negedge clk);
      end
      n_checks++; if (bus.drop_done !== 1'b1) $display("FAIL %s_done_pulse: got %b expected 1", name, bus.drop_done); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.drop_done !== 1'b0) $display("FAIL %s_done_single: got %b expected 0", name, bus.drop_done); else n_pass++;
      for (int i = 0; i < 12; i++) begin
         n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL %s_no_rerequest cyc=%0d: got %b expected 0", name, i, bus.hatch_req); else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (bus.hatch_fault !== 1'b0) $display("FAIL %s_fault_clear: got %b expected 0", name, bus.hatch_fault); else n_pass++;
   endtask

   task automatic test_normal_handshake();
      run_handshake(5, 3, 1'b0, "handshake");
      for (int k = 0; k < 5; k++) begin
         run_handshake($urandom_range(1, 19), $urandom_range(1, 10), 1'($urandom_range(0, 1)), "rand_handshake");
      end
   endtask

   task automatic test_ack_race();
      run_handshake(20, 2, 1'b0, "ack_race");
   endtask

   task automatic test_reset_mid_request();
      bus.drop_activated = 1'b0;
      bus.hatch_ack = 1'b0;
      repeat (2) @(negedge clk);
      bus.drop_activated = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.hatch_req !== 1'b1) $display("FAIL rstreq_req_before: got %b expected 1", bus.hatch_req); else n_pass++;
      for (int i = 0; i < 8 && (m_t % 8) != 4; i++) @(negedge clk);
      n_checks++; if (bus.dig_sel !== (4'b0001 << ((m_t / 8) % 4))) $display("FAIL rstreq_dig_before: got %b expected %b", bus.dig_sel, 4'b0001 << ((m_t / 8) % 4)); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL rstreq_req_async: got %b expected 0", bus.hatch_req); else n_pass++;
      n_checks++; if (bus.dig_sel !== 4'd0) $display("FAIL rstreq_dig_async: got %b expected 0", bus.dig_sel); else n_pass++;
      n_checks++; if (bus.seg_out !== 7'd0) $display("FAIL rstreq_seg_async: got %b expected 0", bus.seg_out); else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL rstreq_held_level cyc=%0d: got %b expected 0", i, bus.hatch_req); else n_pass++;
         @(negedge clk);
      end
      bus.drop_activated = 1'b0;
      @(negedge clk);
      bus.drop_activated = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.hatch_req !== 1'b1) $display("FAIL rstreq_new_rise: got %b expected 1", bus.hatch_req); else n_pass++;
   endtask

   task automatic test_timeout();
      int pos, slot;
      logic [3:0] exp_dig;
      logic [6:0] exp_seg;
      @(negedge clk);
      rst_n = 1'b0;
      m_fault = 1'b0;
      bus.drop_activated = 1'b0;
      bus.hatch_ack = 1'b0;
      for (int i = 0; i < 4; i++) in_w[i] = c_cold[i];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      bus.drop_activated = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 20; i++) begin
         n_checks++; if (bus.hatch_req !== 1'b1) $display("FAIL timeout_req_high cyc=%0d: got %b expected 1", i, bus.hatch_req); else n_pass++;
         n_checks++; if (bus.hatch_fault !== 1'b0) $display("FAIL timeout_fault_early cyc=%0d: got %b expected 0", i, bus.hatch_fault); else n_pass++;
         @(negedge clk);
      end
      n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL timeout_req_dropped: got %b expected 0", bus.hatch_req); else n_pass++;
      n_checks++; if (bus.hatch_fault !== 1'b1) $display("FAIL timeout_fault_set: got %b expected 1", bus.hatch_fault); else n_pass++;
      m_fault = 1'b1;
      for (int c = 0; c < 80; c++) begin
         pos  = m_t % 8;
         slot = (m_t / 8) % 4;
         exp_dig = (pos < 2) ? 4'd0 : 4'b0001 << slot;
         exp_seg = (pos < 2) ? 7'd0 : m_frame[slot];
         n_checks++; if (bus.dig_sel !== exp_dig) $display("FAIL fault_dig_sel t=%0d: got %b expected %b", m_t, bus.dig_sel, exp_dig); else n_pass++;
         n_checks++; if (bus.seg_out !== exp_seg) $display("FAIL fault_seg_out t=%0d: got %b expected %b", m_t, bus.seg_out, exp_seg); else n_pass++;
         n_checks++; if (bus.hatch_req !== 1'b0) $display("FAIL fault_no_request t=%0d: got %b expected 0", m_t, bus.hatch_req); else n_pass++;
         n_checks++; if (bus.hatch_fault !== 1'b1) $display("FAIL fault_sticky t=%0d: got %b expected 1", m_t, bus.hatch_fault); else n_pass++;
         if (c == 20) bus.drop_activated = 1'b0;
         if (c == 25) bus.drop_activated = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m_fault = 1'b0;
      bus.drop_activated = 1'b0;
      bus.hatch_ack = 1'b0;
      for (int i = 0; i < 4; i++) in_w[i] = '0;
      test_reset();
      test_cold_display();
      test_mid_frame();
      test_random_display();
      test_normal_handshake();
      test_ack_race();
      test_reset_mid_request();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire
